// File: rtl/sqrt_seq_driver.sv
// rtl/sqrt_seq_driver.sv - operand sequencer and in-line result checker for the iterative sqrt unit
// Restarts the sqrt unit once per operand and grades each result against floor(sqrt(val)).
module sqrt_seq_driver #(
  parameter int WIDTH    = 16,
  parameter int HOLD_CYC = 7,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     first_val,
  input  logic [WIDTH-1:0]     last_val,
  output logic [WIDTH-1:0]     sqrt_val,
  output logic                 sqrt_rst,
  input  logic [WIDTH/2-1:0]   sqrt_out,
  input  logic                 sqrt_eop,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [CNT_W-1:0]     tmo_cnt,
  output logic [WIDTH-1:0]     last_bad_val
);

  localparam int RW = WIDTH / 2;
  localparam int AW = WIDTH + 2;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sqrt_val_q, sqrt_val_d;
  logic [WIDTH-1:0]  last_q, last_d;
  logic              sqrt_rst_q, sqrt_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  fail_q, fail_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic [WIDTH-1:0]  bad_q, bad_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic [RW-1:0]     res_q, res_d;
  logic              eop_q, eop_d;

  logic              eop_rise;
  logic [AW-1:0]     sq, nx, val_ext;
  logic              check_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign eop_rise = sqrt_eop & ~eop_q;

  // Extra two bits keep r*r + 2r + 1 from overflowing when r is all ones.
  assign val_ext  = AW'(sqrt_val_q);
  assign sq       = AW'(res_q) * AW'(res_q);
  assign nx       = sq + (AW'(res_q) << 1) + AW'(1);
  assign check_ok = (sq <= val_ext) && (val_ext < nx);

  always_comb begin
    state_d    = state_q;
    sqrt_val_d = sqrt_val_q;
    last_d     = last_q;
    sqrt_rst_d = sqrt_rst_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    tmo_d      = tmo_q;
    bad_d      = bad_q;
    hold_d     = hold_q;
    wait_d     = wait_q;
    res_d      = res_q;
    eop_d      = sqrt_eop;

    case (state_q)
      S_IDLE: begin
        sqrt_rst_d = 1'b0;
        if (en) begin
          last_d = last_val;
          pass_d = '0;
          fail_d = '0;
          tmo_d  = '0;
          bad_d  = '0;
          if (last_val < first_val) begin
            state_d = S_DONE;
          end else begin
            sqrt_val_d = first_val;
            hold_d     = '0;
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (hold_q == HW'(HOLD_CYC - 1)) begin
          sqrt_rst_d = 1'b1;
          wait_d     = '0;
          state_d    = S_RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_RUN: begin
        // A level already high when RUN starts is stale; only a fresh edge counts.
        if (eop_rise) begin
          res_d   = sqrt_out;
          state_d = S_CHECK;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          fail_d     = sat_inc(fail_q);
          tmo_d      = sat_inc(tmo_q);
          bad_d      = sqrt_val_q;
          sqrt_rst_d = 1'b0;
          state_d    = S_NEXT;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_CHECK: begin
        if (check_ok) begin
          pass_d = sat_inc(pass_q);
        end else begin
          fail_d = sat_inc(fail_q);
          bad_d  = sqrt_val_q;
        end
        sqrt_rst_d = 1'b0;
        state_d    = S_NEXT;
      end
      S_NEXT: begin
        sqrt_rst_d = 1'b0;
        if ((sqrt_val_q == last_q) || !en) begin
          state_d = S_DONE;
        end else begin
          sqrt_val_d = sqrt_val_q + WIDTH'(1);
          hold_d     = '0;
          state_d    = S_LOAD;
        end
      end
      S_DONE: begin
        sqrt_rst_d = 1'b0;
        if (!en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sqrt_val_q <= '0;
      last_q     <= '0;
      sqrt_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= '0;
      fail_q     <= '0;
      tmo_q      <= '0;
      bad_q      <= '0;
      hold_q     <= '0;
      wait_q     <= '0;
      res_q      <= '0;
      eop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sqrt_val_q <= sqrt_val_d;
      last_q     <= last_d;
      sqrt_rst_q <= sqrt_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      tmo_q      <= tmo_d;
      bad_q      <= bad_d;
      hold_q     <= hold_d;
      wait_q     <= wait_d;
      res_q      <= res_d;
      eop_q      <= eop_d;
    end
  end

  assign sqrt_val     = sqrt_val_q;
  assign sqrt_rst     = sqrt_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;
  assign tmo_cnt      = tmo_q;
  assign last_bad_val = bad_q;

endmodule

// File: tb/tb_sqrt_seq_driver.sv
// tb/tb_sqrt_seq_driver.sv - self-checking bench for sqrt_seq_driver with a behavioural sqrt unit
// The sqrt unit model can return a wrong result, never finish, or hold eop stuck high.
module tb_sqrt_seq_driver;
  localparam int WIDTH = 16;
  localparam int HOLD  = 7;
  localparam int TMO   = 64;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [WIDTH-1:0]  first_val = '0;
  logic [WIDTH-1:0]  last_val = '0;
  logic [WIDTH-1:0]  sqrt_val;
  logic              sqrt_rst;
  logic [7:0]        sqrt_out;
  logic              sqrt_eop;
  logic              busy, done;
  logic [CNT_W-1:0]  pass_cnt, fail_cnt, tmo_cnt;
  logic [WIDTH-1:0]  last_bad_val;

  int n_checks = 0;
  int n_fails  = 0;

  sqrt_seq_driver #(.WIDTH(WIDTH), .HOLD_CYC(HOLD), .TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .first_val(first_val), .last_val(last_val),
    .sqrt_val(sqrt_val), .sqrt_rst(sqrt_rst), .sqrt_out(sqrt_out), .sqrt_eop(sqrt_eop),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .tmo_cnt(tmo_cnt), .last_bad_val(last_bad_val)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural sqrt unit with fault knobs
  int   bad_en = 0, bad_val = -1, hang_en = 0, hang_val = -1;
  int   lat_fixed = 0;
  logic stuck = 1'b0;
  int   u_cnt = 0, u_lat = 1;
  logic u_eop_int = 1'b0;
  logic [7:0] u_out = '0;

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic logic [7:0] unit_result(input int v);
    int r = isqrt(v);
    if (bad_en != 0 && v == bad_val) r = r + 1;
    return 8'(r);
  endfunction

  always @(posedge clk) begin
    if (!sqrt_rst) begin
      u_cnt     <= 0;
      u_eop_int <= 1'b0;
      u_lat     <= (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 20));
    end else begin
      u_cnt <= u_cnt + 1;
      if (u_cnt == u_lat && !(hang_en != 0 && int'(sqrt_val) == hang_val)) begin
        u_eop_int <= 1'b1;
        u_out     <= unit_result(int'(sqrt_val));
      end
    end
  end

  assign sqrt_eop = stuck | u_eop_int;
  assign sqrt_out = u_out;

  // Observes restart pulse widths and timeout latency
  int cyc = 0, low_cnt = 0, hold_seen = 0, hold_bad = 0, rise_cyc = 0, tmo_lat = -1;
  logic [WIDTH-1:0] prev_val = '0;
  logic prev_rst = 1'b0;
  logic [CNT_W-1:0] prev_tmo = '0;

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_val <= sqrt_val;
    prev_rst <= sqrt_rst;
    prev_tmo <= tmo_cnt;
    if (!busy) low_cnt <= 0;
    else if (sqrt_rst && !prev_rst) begin
      hold_seen <= hold_seen + 1;
      if (low_cnt != HOLD) hold_bad <= hold_bad + 1;
      low_cnt  <= 0;
      rise_cyc <= cyc;
    end else if (sqrt_val !== prev_val) low_cnt <= sqrt_rst ? 0 : 1;
    else if (!sqrt_rst) low_cnt <= low_cnt + 1;
    if (tmo_cnt != prev_tmo && tmo_cnt != '0) tmo_lat <= cyc - rise_cyc;
  end

  task automatic start_and_wait(input string name, input int f, input int l, input int budget);
    int n = 0;
    first_val = WIDTH'(f);
    last_val  = WIDTH'(l);
    en = 1'b1;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fails++;
      $display("FAIL %s done_wait: done=%b after %0d cycles, required 1", name, done, n);
    end
  endtask

  task automatic check_range(input string name, input int f, input int l);
    int ep = 0, ef = 0, et = 0, eb = 0, hs0, hb0;
    for (int v = f; v <= l; v++) begin
      if (hang_en != 0 && v == hang_val) begin ef++; et++; eb = v; end
      else if (bad_en != 0 && v == bad_val) begin ef++; eb = v; end
      else ep++;
    end
    hs0 = hold_seen;
    hb0 = hold_bad;
    start_and_wait(name, f, l, (l - f + 1) * (HOLD + TMO + 30) + 20);
    n_checks++;
    if (pass_cnt !== CNT_W'(ep)) begin n_fails++; $display("FAIL %s pass_cnt: got %0d want %0d", name, pass_cnt, ep); end
    n_checks++;
    if (fail_cnt !== CNT_W'(ef)) begin n_fails++; $display("FAIL %s fail_cnt: got %0d want %0d", name, fail_cnt, ef); end
    n_checks++;
    if (tmo_cnt !== CNT_W'(et)) begin n_fails++; $display("FAIL %s tmo_cnt: got %0d want %0d", name, tmo_cnt, et); end
    n_checks++;
    if (last_bad_val !== WIDTH'(eb)) begin n_fails++; $display("FAIL %s last_bad_val: got %0d want %0d", name, last_bad_val, eb); end
    n_checks++;
    if (hold_seen - hs0 != l - f + 1 || hold_bad != hb0) begin
      n_fails++;
      $display("FAIL %s restart_pulses: got %0d releases with %0d bad widths, want %0d releases each after %0d low cycles",
               name, hold_seen - hs0, hold_bad - hb0, l - f + 1, HOLD);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL %s return_idle: done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sqrt_val, sqrt_rst, busy, done, pass_cnt, fail_cnt, tmo_cnt, last_bad_val} !== '0) begin
      n_fails++;
      $display("FAIL reset_state: val=%0d rst=%b busy=%b done=%b pass=%0d fail=%0d tmo=%0d bad=%0d, want all 0",
               sqrt_val, sqrt_rst, busy, done, pass_cnt, fail_cnt, tmo_cnt, last_bad_val);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    check_range("basic_4_9", 4, 9);
  endtask

  task automatic test_bad_result();
    bad_en = 1; bad_val = 8;
    check_range("bad_result_8", 4, 9);
    bad_en = 0;
  endtask

  task automatic test_timeout();
    hang_en = 1; hang_val = 6;
    check_range("timeout_6", 5, 7);
    hang_en = 0;
    n_checks++;
    if (tmo_lat != TMO) begin n_fails++; $display("FAIL timeout_latency: got %0d cycles want %0d", tmo_lat, TMO); end
  endtask

  task automatic test_top_range();
    check_range("top_range", 65534, 65535);
    n_checks++;
    if (sqrt_val !== 16'hFFFF) begin n_fails++; $display("FAIL top_no_wrap: sqrt_val=%0d want 65535", sqrt_val); end
  endtask

  task automatic test_empty();
    int n = 0, hs0 = hold_seen;
    first_val = 16'd10;
    last_val  = 16'd3;
    en = 1'b1;
    @(negedge clk);
    while (!done && n < 2) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (done !== 1'b1) begin n_fails++; $display("FAIL empty_done: done=%b want 1 within 2 cycles", done); end
    n_checks++;
    if ({pass_cnt, fail_cnt, tmo_cnt, last_bad_val} !== '0) begin
      n_fails++;
      $display("FAIL empty_counts: pass=%0d fail=%0d tmo=%0d bad=%0d want all 0", pass_cnt, fail_cnt, tmo_cnt, last_bad_val);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (hold_seen != hs0 || sqrt_rst !== 1'b0) begin
      n_fails++;
      $display("FAIL empty_no_release: releases=%0d sqrt_rst=%b want 0 0", hold_seen - hs0, sqrt_rst);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    int n = 0;
    first_val = 16'd100;
    last_val  = 16'd110;
    en = 1'b1;
    while (pass_cnt != 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    en = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (done !== 1'b1 || pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin
      n_fails++;
      $display("FAIL abort: done=%b pass=%0d fail=%0d want 1 1 0", done, pass_cnt, fail_cnt);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    lat_fixed = 15;
    first_val = 16'd0;
    last_val  = 16'd3;
    en = 1'b1;
    while (sqrt_rst !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({sqrt_val, sqrt_rst, busy, done, pass_cnt, fail_cnt, tmo_cnt, last_bad_val} !== '0) begin
      n_fails++;
      $display("FAIL mid_run_reset: val=%0d rst=%b busy=%b done=%b pass=%0d fail=%0d tmo=%0d, want all 0",
               sqrt_val, sqrt_rst, busy, done, pass_cnt, fail_cnt, tmo_cnt);
    end
    lat_fixed = 0;
  endtask

  task automatic test_stuck_eop();
    int n = 0;
    lat_fixed = 30;
    stuck = 1'b1;
    first_val = 16'd20;
    last_val  = 16'd20;
    en = 1'b1;
    while (sqrt_rst !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || busy !== 1'b1) begin
      n_fails++;
      $display("FAIL stuck_eop_ignored: pass=%0d fail=%0d busy=%b want 0 0 1", pass_cnt, fail_cnt, busy);
    end
    stuck = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (done !== 1'b1 || pass_cnt !== 16'd1 || fail_cnt !== 16'd0 || tmo_cnt !== 16'd0) begin
      n_fails++;
      $display("FAIL stuck_eop_fresh_edge: done=%b pass=%0d fail=%0d tmo=%0d want 1 1 0 0", done, pass_cnt, fail_cnt, tmo_cnt);
    end
    en = 1'b0;
    lat_fixed = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int f   = int'($urandom_range(0, 1000));
      int len = int'($urandom_range(0, 5));
      bad_en   = int'($urandom_range(0, 1));
      bad_val  = f + int'($urandom_range(0, len));
      hang_en  = int'($urandom_range(0, 1));
      hang_val = f + int'($urandom_range(0, len));
      check_range($sformatf("random_%0d", it), f, f + len);
    end
    bad_en  = 0;
    hang_en = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_result();
    test_timeout();
    test_top_range();
    test_empty();
    test_abort();
    test_reset_mid_run();
    test_stuck_eop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
